ipsxb_fft_sdpram_rd_ctrl: RTL and testbench
===========================================

# ipsxb_fft_sdpram_rd_ctrl

Read-side sequencer for the FFT's simple dual-port sample/twiddle RAMs. On a start command it walks a frame of addresses into the RAM read port. It tracks the fixed RAM read latency (output register enabled) and delivers the returned words as an AXI4-Stream master with full backpressure support. It sits between the FFT block RAM and the butterfly/output stage, consuming the read port that the write-side logic fills.

## Interface
- ADDR_W, 9, RAM read address width; all address arithmetic is modulo 2^ADDR_W.
- DATA_W, 54, RAM read data / stream data width.
- RD_LAT, 2, RAM read latency in cycles from address presented to data valid; legal values are 1 or 2.
- FIFO_DEPTH, 4, output skid FIFO depth; must be at least RD_LAT+2 for 1 word/cycle throughput; must be a power of 2.
- i_aclk  in  1  single clock for the block and the RAM read port.
- i_aresetn  in  1  asynchronous, active-low reset.
- i_start  in  1  one-cycle frame start; ignored while o_busy=1.
- i_base_addr  in  ADDR_W  first RAM address of the frame; sampled with i_start.
- i_len_m1  in  ADDR_W  frame length minus 1; sampled with i_start.
- o_busy  out  1  frame in progress.
- o_done  out  1  one-cycle pulse after the last beat is accepted.
- o_ram_rd_addr  out  ADDR_W  registered RAM read address.
- o_ram_rd_clk_en  out  1  RAM read clock enable.
- o_ram_rd_oce  out  1  RAM output register enable.
- i_ram_rd_data  in  DATA_W  RAM read data.
- o_axi4s_tdata  out  DATA_W  stream data.
- o_axi4s_tvalid  out  1  stream valid.
- i_axi4s_tready  in  1  stream ready.
- o_axi4s_tlast  out  1  last beat of frame.

## Operation
- FSM states:
  - IDLE: accept i_start, latch base and length, clear idx, go to ISSUE.
  - ISSUE: issue one read per cycle when credit is available; after index len_m1 is issued, go to DRAIN.
  - DRAIN: wait until in-flight=0, FIFO is empty, and the last beat handshakes; then go to DONE.
  - DONE: pulse o_done for one cycle, then go to IDLE.
- Read address is base + idx, computed mod 2^ADDR_W. Wrap past the top of the RAM is legal and silent.
- Credit rule: issue only when FIFO count + in-flight count < FIFO_DEPTH. Reads therefore never overflow the FIFO, and no data is ever dropped.
- A valid/last tag shift register of length RD_LAT runs alongside each read. The word is pushed into the FIFO in the cycle its tag exits the shift register.
- tlast travels with the word issued at idx=len_m1. A frame with len_m1=0 is a single beat with tlast=1.
- o_ram_rd_clk_en and o_ram_rd_oce are 1 whenever o_busy=1 or in-flight≠0, and 0 otherwise.
- Once asserted, tvalid and tdata hold stable until the handshake (AXI rule).
- Reset mid-frame: everything is cleared immediately. In-flight RAM data arriving after release is discarded, because its tags are cleared.

## Timing
- Reset values: o_busy, o_done, tvalid, tlast, o_ram_rd_clk_en, o_ram_rd_oce are 0; o_ram_rd_addr and tdata are 0.
- i_start sampled at cycle 0:
  - o_busy=1 and first o_ram_rd_addr in cycle 1.
  - Data returns in cycle 1+RD_LAT.
  - First tvalid in cycle 2+RD_LAT (cycle 4 at default).
- With tready held high: 1 beat/cycle, no gaps. An N-beat frame ends its last beat at cycle RD_LAT+N+1.
- o_done=1 in the cycle after the last handshake; o_busy=0 in that same cycle.
- An i_start arriving in the o_done cycle is accepted.

## Configuration
- IPSXB_FFT_RD_BITREV_EN defined:
  - Adds input ports i_bitrev (1 bit) and i_log2n (5 bits), both sampled with i_start.
  - When i_bitrev=1: frame length is 2^i_log2n (i_len_m1 is ignored), and the address is base + bit-reverse of the low i_log2n bits of idx.
  - i_log2n must be ≤ ADDR_W.
- Not defined: the ports are absent and addressing is always linear.

## Structure
- Package ipsxb_fft_rd_pkg holds:
  - the FSM state enum (IDLE, ISSUE, DRAIN, DONE);
  - the bit-reverse function;
  - the LOG2N_W=5 constant.
- Sub-module ipsxb_fft_rd_skid_fifo: synchronous FIFO, FIFO_DEPTH×(DATA_W+1) with the tlast bit, show-ahead output, and a count output for the credit logic.

## Test plan
- Start with base=0x010, len_m1=7, tready=1, RAM model returning data=address. Expect 8 beats with data 0x010..0x017 in cycles 4..11, tlast only on 0x017, o_done in cycle 12.
- Same frame with tready toggling 1/0 every cycle. Expect the same 8 values in order, tdata stable while stalled, and never more than 4 words outstanding.
- Wrap: base=0x1FE, len_m1=3. Expect addresses 0x1FE, 0x1FF, 0x000, 0x001.
- Boundary: len_m1=0. Expect a single beat with tlast=1; a second i_start in the o_done cycle starts a new frame. An i_start during o_busy is ignored.
- Reset: assert i_aresetn=0 mid-frame, at beat 3 of 8. All outputs go to 0 immediately; after release, no stale beats appear and a fresh frame runs correctly.
- With IPSXB_FFT_RD_BITREV_EN: base=0, i_bitrev=1, i_log2n=3. Expect addresses 0,4,2,6,1,5,3,7.

Source files
------------

// File: rtl/ipsxb_fft_rd_pkg.sv
// ipsxb_fft_rd_pkg: shared types and helpers for the FFT SDPRAM read sequencer.
package ipsxb_fft_rd_pkg;

    localparam int LOG2N_W = 5;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} rd_state_e;

    // Reverse the low n bits of v; bits at or above n are dropped.
    function automatic logic [31:0] bitrev(input logic [31:0] v, input logic [LOG2N_W-1:0] n);
        logic [31:0] r;
        r = {<<{v}};
        return r >> (6'd32 - {1'b0, n});
    endfunction

endpackage

// File: rtl/ipsxb_fft_rd_skid_fifo.sv
// ipsxb_fft_rd_skid_fifo: show-ahead synchronous FIFO with occupancy count for read credit.
module ipsxb_fft_rd_skid_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 55
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic [W-1:0]             o_dout,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr;
    logic [AW-1:0] r_rd;
    logic [AW:0]   r_cnt;
    logic          w_push;
    logic          w_pop;

    assign w_pop   = i_pop && (r_cnt != '0);
    assign w_push  = i_push && (r_cnt != (AW+1)'(DEPTH));
    assign o_dout  = r_mem[r_rd];
    assign o_empty = (r_cnt == '0);
    assign o_count = r_cnt;

    // Storage array; needs no reset since reads are gated by the count.
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    // Pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

endmodule

// File: rtl/ipsxb_fft_sdpram_rd_ctrl.sv
// ipsxb_fft_sdpram_rd_ctrl: frame read sequencer from SDPRAM to AXI4-Stream with
// latency tracking and credit-based skid FIFO. Define IPSXB_FFT_RD_BITREV_EN to add
// bit-reversed addressing (i_bitrev / i_log2n).
module ipsxb_fft_sdpram_rd_ctrl
    import ipsxb_fft_rd_pkg::*;
#(
    parameter int ADDR_W     = 9,
    parameter int DATA_W     = 54,
    parameter int RD_LAT     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                i_aclk,
    input  logic                i_aresetn,
    input  logic                i_start,
    input  logic [ADDR_W-1:0]   i_base_addr,
    input  logic [ADDR_W-1:0]   i_len_m1,
`ifdef IPSXB_FFT_RD_BITREV_EN
    input  logic                i_bitrev,
    input  logic [LOG2N_W-1:0]  i_log2n,
`endif
    output logic                o_busy,
    output logic                o_done,
    output logic [ADDR_W-1:0]   o_ram_rd_addr,
    output logic                o_ram_rd_clk_en,
    output logic                o_ram_rd_oce,
    input  logic [DATA_W-1:0]   i_ram_rd_data,
    output logic [DATA_W-1:0]   o_axi4s_tdata,
    output logic                o_axi4s_tvalid,
    input  logic                i_axi4s_tready,
    output logic                o_axi4s_tlast
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    rd_state_e           r_state;
    rd_state_e           w_state_nxt;
    logic [ADDR_W-1:0]   r_base;
    logic [ADDR_W-1:0]   r_len_m1;
    logic [ADDR_W-1:0]   r_idx;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_addr_vld;
    logic                r_addr_last;
    logic [RD_LAT-1:0]   r_tag_vld;
    logic [RD_LAT-1:0]   r_tag_last;
    logic [ADDR_W-1:0]   w_next_idx;
    logic [ADDR_W-1:0]   w_next_off;
    logic [ADDR_W-1:0]   w_start_len;
    logic                w_start;
    logic                w_issue;
    logic                w_credit;
    logic                w_push;
    logic                w_pop;
    logic                w_empty;
    logic                w_last;
    logic                w_busy;
    logic [CW-1:0]       w_cnt;
    logic [DATA_W:0]     w_dout;
    logic [7:0]          w_inflight;
    logic [7:0]          w_occ;

`ifdef IPSXB_FFT_RD_BITREV_EN
    logic                r_bitrev;
    logic [LOG2N_W-1:0]  r_log2n;

    assign w_start_len = i_bitrev ? ADDR_W'((33'd1 << i_log2n) - 33'd1) : i_len_m1;
    assign w_next_off  = r_bitrev ? ADDR_W'(bitrev(32'(w_next_idx), r_log2n)) : w_next_idx;

    // Addressing mode captured with the start command.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_bitrev <= 1'b0;
            r_log2n  <= '0;
        end else if (w_start) begin
            r_bitrev <= i_bitrev;
            r_log2n  <= i_log2n;
        end
    end
`else
    assign w_start_len = i_len_m1;
    assign w_next_off  = w_next_idx;
`endif

    // A start is taken in IDLE and also in DONE so frames can run back to back.
    assign w_start    = i_start && (r_state == IDLE || r_state == DONE);
    assign w_next_idx = r_idx + 1'b1;
    // In flight: the address on the RAM port this cycle plus every tag in the latency pipe.
    assign w_inflight = 8'($countones(r_tag_vld)) + 8'(r_addr_vld);
    // A word popped this cycle frees its slot, which keeps 1 beat/cycle at the minimum depth.
    assign w_occ      = 8'(w_cnt) + w_inflight - 8'(w_pop);
    assign w_credit   = w_occ < 8'(FIFO_DEPTH);
    assign w_issue    = (r_state == ISSUE) && w_credit;
    assign w_push     = r_tag_vld[RD_LAT-1];
    assign w_pop      = !w_empty && i_axi4s_tready;
    assign w_last     = w_dout[DATA_W];

    // State register.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) r_state <= IDLE;
        else            r_state <= w_state_nxt;
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE, DONE: w_state_nxt = w_start ? ((w_start_len == '0) ? DRAIN : ISSUE) : IDLE;
            ISSUE:      if (w_issue && w_next_idx == r_len_m1) w_state_nxt = DRAIN;
            DRAIN:      if (w_pop && w_last && w_inflight == 8'd0) w_state_nxt = DONE;
            default:    w_state_nxt = IDLE;
        endcase
    end

    // State-decoded outputs.
    always_comb begin
        w_busy = (r_state == ISSUE) || (r_state == DRAIN);
        o_done = (r_state == DONE);
    end

    // Frame parameters, read index and registered RAM address.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_base      <= '0;
            r_len_m1    <= '0;
            r_idx       <= '0;
            r_addr      <= '0;
            r_addr_vld  <= 1'b0;
            r_addr_last <= 1'b0;
        end else if (w_start) begin
            r_base      <= i_base_addr;
            r_len_m1    <= w_start_len;
            r_idx       <= '0;
            r_addr      <= i_base_addr;
            r_addr_vld  <= 1'b1;
            r_addr_last <= (w_start_len == '0);
        end else if (w_issue) begin
            r_idx       <= w_next_idx;
            r_addr      <= r_base + w_next_off;
            r_addr_vld  <= 1'b1;
            r_addr_last <= (w_next_idx == r_len_m1);
        end else begin
            r_addr_vld  <= 1'b0;
            r_addr_last <= 1'b0;
        end
    end

    // Valid/last tags follow each read through the RAM latency; reset drops stale reads.
    always_ff @(posedge i_aclk or negedge i_aresetn) begin
        if (!i_aresetn) begin
            r_tag_vld  <= '0;
            r_tag_last <= '0;
        end else begin
            r_tag_vld  <= RD_LAT'({r_tag_vld, r_addr_vld});
            r_tag_last <= RD_LAT'({r_tag_last, r_addr_vld && r_addr_last});
        end
    end

    ipsxb_fft_rd_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (DATA_W + 1)
    ) u_fifo (
        .i_clk   (i_aclk),
        .i_rst_n (i_aresetn),
        .i_push  (w_push),
        .i_din   ({r_tag_last[RD_LAT-1], i_ram_rd_data}),
        .i_pop   (w_pop),
        .o_dout  (w_dout),
        .o_empty (w_empty),
        .o_count (w_cnt)
    );

    assign o_busy          = w_busy;
    assign o_ram_rd_addr   = r_addr;
    assign o_ram_rd_clk_en = w_busy || (w_inflight != 8'd0);
    assign o_ram_rd_oce    = w_busy || (w_inflight != 8'd0);
    assign o_axi4s_tvalid  = !w_empty;
    assign o_axi4s_tdata   = w_empty ? '0 : w_dout[DATA_W-1:0];
    assign o_axi4s_tlast   = !w_empty && w_last;

endmodule

// File: tb/tb_ipsxb_fft_sdpram_rd_ctrl.sv
// tb_ipsxb_fft_sdpram_rd_ctrl: directed bench for the FFT SDPRAM read sequencer.
module tb_ipsxb_fft_sdpram_rd_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [8:0]  base_addr;
    logic [8:0]  len_m1;
    logic        busy;
    logic        done;
    logic [8:0]  addr;
    logic        clk_en;
    logic        oce;
    logic [53:0] ram_q1;
    logic [53:0] ram_q2;
    logic [53:0] tdata;
    logic        tvalid;
    logic        tready;
    logic        tlast;
`ifdef IPSXB_FFT_RD_BITREV_EN
    logic        bitrev_en;
    logic [4:0]  log2n;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // RAM model: data equals address, two-cycle latency with output register.
    always @(posedge clk) begin
        if (clk_en) ram_q1 <= 54'(addr);
        if (oce) ram_q2 <= ram_q1;
    end

    ipsxb_fft_sdpram_rd_ctrl dut (
        .i_aclk          (clk),
        .i_aresetn       (rst_n),
        .i_start         (start),
        .i_base_addr     (base_addr),
        .i_len_m1        (len_m1),
`ifdef IPSXB_FFT_RD_BITREV_EN
        .i_bitrev        (bitrev_en),
        .i_log2n         (log2n),
`endif
        .o_busy          (busy),
        .o_done          (done),
        .o_ram_rd_addr   (addr),
        .o_ram_rd_clk_en (clk_en),
        .o_ram_rd_oce    (oce),
        .i_ram_rd_data   (ram_q2),
        .o_axi4s_tdata   (tdata),
        .o_axi4s_tvalid  (tvalid),
        .i_axi4s_tready  (tready),
        .o_axi4s_tlast   (tlast)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Linear frame with tready high: beats in cycles 4..4+len_m1, o_done right after.
    task automatic run_frame(input logic [8:0] base, input logic [8:0] lm1);
        logic [8:0] a;
        start = 1'b1;
        base_addr = base;
        len_m1 = lm1;
        tready = 1'b1;
        tick;
        start = 1'b0;
        chk("busy_c1", busy, 1);
        chk("addr_c1", addr, base);
        tick;
        tick;
        chk("tvalid_c3", tvalid, 0);
        for (int k = 0; k <= int'(lm1); k++) begin
            tick;
            a = base + 9'(k);
            chk("beat_valid", tvalid, 1);
            chk("beat_data", tdata, a);
            chk("beat_last", tlast, (k == int'(lm1)));
        end
        tick;
        chk("done_pulse", done, 1);
        chk("done_busy", busy, 0);
        chk("done_tvalid", tvalid, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int beats;
        int issued;
        int acc;
        logic [8:0]  last_addr;
        logic        prev_stall;
        logic [53:0] prev_data;
        logic        done_seen;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        len_m1 = '0;
        tready = 1'b0;
`ifdef IPSXB_FFT_RD_BITREV_EN
        bitrev_en = 1'b0;
        log2n = '0;
`endif
        tick;
        tick;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_tvalid", tvalid, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_clk_en", clk_en, 0);
        chk("rst_oce", oce, 0);
        chk("rst_addr", addr, 0);
        chk("rst_tdata", tdata, 0);
        rst_n = 1'b1;
        tick;

        // Basic 8-beat frame.
        run_frame(9'h010, 9'd7);
        tick;
        chk("done_one_cycle", done, 0);
        chk("idle_clk_en", clk_en, 0);

        // Same frame with tready toggling.
        beats = 0;
        issued = 0;
        acc = 0;
        last_addr = '0;
        prev_stall = 1'b0;
        prev_data = '0;
        done_seen = 1'b0;
        start = 1'b1;
        base_addr = 9'h010;
        len_m1 = 9'd7;
        tick;
        start = 1'b0;
        for (int c = 1; c < 60 && !done_seen; c++) begin
            tready = c[0];
            if (c == 1 || addr != last_addr) issued++;
            last_addr = addr;
            chk("outstanding_le4", (issued - acc <= 4), 1);
            if (tvalid) begin
                if (prev_stall) chk("stall_hold", tdata, prev_data);
                if (tready) begin
                    chk("tog_data", tdata, 9'h010 + 9'(beats));
                    chk("tog_last", tlast, (beats == 7));
                    beats++;
                    acc++;
                end
                prev_stall = !tready;
                prev_data = tdata;
            end else begin
                prev_stall = 1'b0;
            end
            if (done) done_seen = 1'b1;
            tick;
        end
        chk("tog_beats", beats, 8);
        chk("tog_done_seen", done_seen, 1);
        tready = 1'b1;
        tick;

        // Address wrap past the top of the RAM.
        run_frame(9'h1FE, 9'd3);
        tick;

        // Single-beat frame, ignored start while busy, back-to-back start on o_done.
        start = 1'b1;
        base_addr = 9'h033;
        len_m1 = 9'd0;
        tick;
        chk("len0_busy", busy, 1);
        chk("len0_addr", addr, 9'h033);
        base_addr = 9'h0AA;
        len_m1 = 9'd5;
        tick;
        start = 1'b0;
        chk("ign_busy", busy, 1);
        chk("ign_addr", addr, 9'h033);
        tick;
        chk("len0_tvalid_c3", tvalid, 0);
        tick;
        chk("len0_valid", tvalid, 1);
        chk("len0_data", tdata, 9'h033);
        chk("len0_last", tlast, 1);
        tick;
        chk("len0_done", done, 1);
        chk("len0_tvalid_c5", tvalid, 0);
        start = 1'b1;
        base_addr = 9'h055;
        len_m1 = 9'd1;
        tick;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_addr", addr, 9'h055);
        tick;
        tick;
        chk("b2b_tvalid_c3", tvalid, 0);
        tick;
        chk("b2b_data0", tdata, 9'h055);
        chk("b2b_last0", tlast, 0);
        tick;
        chk("b2b_data1", tdata, 9'h056);
        chk("b2b_last1", tlast, 1);
        tick;
        chk("b2b_done", done, 1);
        tick;

        // Reset mid-frame at beat 3 of 8.
        start = 1'b1;
        base_addr = 9'h100;
        len_m1 = 9'd7;
        tick;
        start = 1'b0;
        for (int c = 2; c <= 6; c++) tick;
        chk("mid_beat3", tdata, 9'h102);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_tvalid", tvalid, 0);
        chk("mid_rst_tdata", tdata, 0);
        chk("mid_rst_addr", addr, 0);
        chk("mid_rst_clk_en", clk_en, 0);
        tick;
        tick;
        rst_n = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick;
            chk("no_stale", tvalid, 0);
        end
        run_frame(9'h020, 9'd3);
        tick;

`ifdef IPSXB_FFT_RD_BITREV_EN
        // Bit-reversed 8-point frame.
        begin
            logic [8:0] exp_br [8];
            exp_br = '{9'd0, 9'd4, 9'd2, 9'd6, 9'd1, 9'd5, 9'd3, 9'd7};
            start = 1'b1;
            base_addr = '0;
            len_m1 = '0;
            bitrev_en = 1'b1;
            log2n = 5'd3;
            tick;
            start = 1'b0;
            tick;
            tick;
            for (int k = 0; k < 8; k++) begin
                tick;
                chk("br_data", tdata, exp_br[k]);
                chk("br_last", tlast, (k == 7));
            end
            tick;
            chk("br_done", done, 1);
            bitrev_en = 1'b0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
